// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory bus between the I-cache and D-cache miss/write ports.
//   Each cache's one-cycle request pulse is latched into a per-port pending slot.
//   The arbiter grants one port at a time and uses round robin when both wait.
//   A read miss becomes an aligned BEATS-beat line fill, and the beats are
//   assembled into a BLOCKSZ-bit line. A write is a single-beat pass-through.
//   Each completion is returned as a one-cycle *_data_valid pulse.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   ic_req/ic_addr/ic_wr_en/ic_data_in    I-cache request (req is a 1-cycle pulse)
//   ic_data_out/ic_data_valid             filled line / completion pulse to I-cache
//   dc_*                                  D-cache port, same shape as ic_*
//   bus_req/bus_addr/bus_wr_en/bus_wdata  bus address phase (held until bus_ack)
//   bus_ack                               address phase accepted
//   bus_rdata/bus_rvalid                  read beats
//   bus_wdone                             write completed
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int BLOCKSZ     = 512,
  parameter int WIDTH       = 64,
  parameter int ADDRESSSIZE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ic_req,
  input  logic [ADDRESSSIZE-1:0] ic_addr,
  input  logic                   ic_wr_en,
  input  logic [WIDTH-1:0]       ic_data_in,
  output logic [BLOCKSZ-1:0]     ic_data_out,
  output logic                   ic_data_valid,
  input  logic                   dc_req,
  input  logic [ADDRESSSIZE-1:0] dc_addr,
  input  logic                   dc_wr_en,
  input  logic [WIDTH-1:0]       dc_data_in,
  output logic [BLOCKSZ-1:0]     dc_data_out,
  output logic                   dc_data_valid,
  output logic                   bus_req,
  output logic [ADDRESSSIZE-1:0] bus_addr,
  output logic                   bus_wr_en,
  output logic [WIDTH-1:0]       bus_wdata,
  input  logic                   bus_ack,
  input  logic [WIDTH-1:0]       bus_rdata,
  input  logic                   bus_rvalid,
  input  logic                   bus_wdone
);

  localparam int BEATS = BLOCKSZ / WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = $clog2(BLOCKSZ);

  localparam logic [CNT_W-1:0]       LAST_BEAT = CNT_W'(BEATS - 1);
  // Reads fetch the whole line, so drop the byte-offset-within-line bits.
  localparam logic [ADDRESSSIZE-1:0] LINE_MASK = ~ADDRESSSIZE'(BLOCKSZ / 8 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Port index used for grant, pending and valid vectors.
  localparam logic PORT_IC = 1'b0;
  localparam logic PORT_DC = 1'b1;

  // Control state
  logic [2:0]             state_q,      state_d;
  logic                   grant_q,      grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [1:0]             pend_q,       pend_d;
  logic [CNT_W-1:0]       beat_cnt_q,   beat_cnt_d;
  logic                   bus_req_q,    bus_req_d;
  logic [ADDRESSSIZE-1:0] bus_addr_q,   bus_addr_d;
  logic                   bus_wr_en_q,  bus_wr_en_d;
  logic [WIDTH-1:0]       bus_wdata_q,  bus_wdata_d;
  logic [BLOCKSZ-1:0]     ic_out_q,     ic_out_d;
  logic [BLOCKSZ-1:0]     dc_out_q,     dc_out_d;
  logic [1:0]             valid_q,      valid_d;

  // Datapath storage
  logic [BLOCKSZ-1:0]     line_q,       line_d;
  logic [ADDRESSSIZE-1:0] lat_addr_q [2];
  logic [WIDTH-1:0]       lat_data_q [2];
  logic [1:0]             lat_wr_q;

  logic [1:0]             req_vec;
  logic [1:0]             clr_vec;
  logic [1:0]             accept;
  logic                   gnt_sel;
  logic [IDX_W-1:0]       beat_base;

  assign req_vec   = {dc_req, ic_req};
  assign beat_base = IDX_W'(beat_cnt_q) * IDX_W'(WIDTH);

  // Pending slots. The slot being retired in DONE may be refilled in the
  // same cycle: a new request wins over the clear.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    clr_vec = '0;
    if (state_q == S_DONE) clr_vec[grant_q] = 1'b1;
    accept = req_vec & (~pend_q | clr_vec);
    pend_d = (pend_q & ~clr_vec) | accept;
  end

  // Round robin only matters when both ports wait; otherwise take the one that does.
  always_comb begin
    if (pend_q == 2'b11) gnt_sel = ~last_grant_q;
    else                 gnt_sel = pend_q[PORT_DC];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    bus_req_d    = bus_req_q;
    bus_addr_d   = bus_addr_q;
    bus_wr_en_d  = bus_wr_en_q;
    bus_wdata_d  = bus_wdata_q;
    ic_out_d     = ic_out_q;
    dc_out_d     = dc_out_q;
    line_d       = line_q;
    valid_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          grant_d     = gnt_sel;
          bus_req_d   = 1'b1;
          bus_wr_en_d = lat_wr_q[gnt_sel];
          if (lat_wr_q[gnt_sel]) begin
            bus_addr_d  = lat_addr_q[gnt_sel];
            bus_wdata_d = lat_data_q[gnt_sel];
          end else begin
            bus_addr_d  = lat_addr_q[gnt_sel] & LINE_MASK;
            bus_wdata_d = '0;
          end
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (bus_ack) begin
          bus_req_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = bus_wr_en_q ? S_WRITE : S_READ;
        end
      end

      S_READ: begin
        if (bus_rvalid) begin
          line_d[beat_base +: WIDTH] = bus_rdata;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            // Publish the finished line together with the valid pulse.
            if (grant_q == PORT_DC) dc_out_d = line_d;
            else                    ic_out_d = line_d;
            valid_d[grant_q] = 1'b1;
            state_d          = S_DONE;
          end
        end
      end

      S_WRITE: begin
        if (bus_wdone) begin
          valid_d[grant_q] = 1'b1;
          state_d          = S_DONE;
        end
      end

      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= S_IDLE;
      grant_q      <= PORT_IC;
      last_grant_q <= PORT_IC;
      pend_q       <= '0;
      beat_cnt_q   <= '0;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_wr_en_q  <= 1'b0;
      bus_wdata_q  <= '0;
      ic_out_q     <= '0;
      dc_out_q     <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      beat_cnt_q   <= beat_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_addr_q   <= bus_addr_d;
      bus_wr_en_q  <= bus_wr_en_d;
      bus_wdata_q  <= bus_wdata_d;
      ic_out_q     <= ic_out_d;
      dc_out_q     <= dc_out_d;
      valid_q      <= valid_d;
    end
  end

  // NOTE: pure data storage is left unreset; it is only read after pend or the beat counter qualifies it.
  always_ff @(posedge clk) begin
    line_q <= line_d;
    if (accept[PORT_IC]) begin
      lat_addr_q[PORT_IC] <= ic_addr;
      lat_data_q[PORT_IC] <= ic_data_in;
      lat_wr_q[PORT_IC]   <= ic_wr_en;
    end
    if (accept[PORT_DC]) begin
      lat_addr_q[PORT_DC] <= dc_addr;
      lat_data_q[PORT_DC] <= dc_data_in;
      lat_wr_q[PORT_DC]   <= dc_wr_en;
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wr_en     = bus_wr_en_q;
  assign bus_wdata     = bus_wdata_q;
  assign ic_data_out   = ic_out_q;
  assign dc_data_out   = dc_out_q;
  assign ic_data_valid = valid_q[PORT_IC];
  assign dc_data_valid = valid_q[PORT_DC];

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. The stimulus thread queues the expected bus
//   transactions and cache completions. A bus responder pops the bus queue and
//   checks each address phase it serves. A completion monitor pops the cache
//   queue on every *_data_valid pulse. All bench activity happens on the falling
//   clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic P_IC = 1'b0;
  localparam logic P_DC = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req, ic_wr_en, dc_req, dc_wr_en;
  logic [63:0]  ic_addr, dc_addr, ic_data_in, dc_data_in;
  logic [511:0] ic_data_out, dc_data_out;
  logic         ic_data_valid, dc_data_valid;
  logic         bus_req, bus_wr_en, bus_ack, bus_rvalid, bus_wdone;
  logic [63:0]  bus_addr, bus_wdata, bus_rdata;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_wr_en(ic_wr_en), .ic_data_in(ic_data_in),
    .ic_data_out(ic_data_out), .ic_data_valid(ic_data_valid),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_wr_en(dc_wr_en), .dc_data_in(dc_data_in),
    .dc_data_out(dc_data_out), .dc_data_valid(dc_data_valid),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_wdone(bus_wdone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         port;
    logic [511:0] data;
  } sb_t;

  typedef struct {
    logic [63:0] addr;
    logic        wr;
    logic [63:0] wdata;
    logic [63:0] rbase;
    int          ack_dly;
    int          gap;
    int          wdly;
  } bus_t;

  sb_t  sb_q[$];
  bus_t bus_q[$];

  logic [511:0] model_out [2];

  // Bookkeeping written only by the responder / monitor processes.
  int beats_sent = 0;
  int txn_cnt    = 0;
  int wdone_cyc  = 0;
  int rises      = 0;
  int valid_cnt [2];
  int valid_cyc [2];
  int spur_req   = 0;
  int spur_done  = 0;

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
    return l;
  endfunction

  // ---------------------------------------------------------------- bus side
  task automatic serve();
    bus_t        e;
    logic [63:0] a0;
    txn_cnt++;
    beats_sent = 0;
    if (bus_q.size() == 0) begin
      check("bus_txn_expected", 512'(bus_q.size()), 512'd1);
      return;
    end
    e = bus_q.pop_front();
    check("bus_addr", 512'(bus_addr), 512'(e.addr));
    check("bus_wr_en", 512'(bus_wr_en), 512'(e.wr));
    if (e.wr) check("bus_wdata", 512'(bus_wdata), 512'(e.wdata));
    a0 = bus_addr;
    for (int i = 0; i < e.ack_dly; i++) begin
      @(negedge clk);
      if (rst) return;
      check("bus_req_hold", 512'(bus_req), 512'd1);
      check("bus_addr_hold", 512'(bus_addr), 512'(a0));
    end
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    if (rst) return;
    check("bus_req_drop", 512'(bus_req), 512'd0);
    if (!e.wr) begin
      for (int b = 0; b < 8; b++) begin
        for (int g = 0; g < ((b == 0) ? 0 : e.gap); g++) begin
          @(negedge clk);
          if (rst) return;
        end
        bus_rvalid = 1'b1;
        bus_rdata  = e.rbase + 64'(b);
        beats_sent = b + 1;
        @(negedge clk);
        bus_rvalid = 1'b0;
        if (rst) return;
      end
    end else begin
      for (int w = 0; w < e.wdly; w++) begin
        @(negedge clk);
        if (rst) return;
      end
      bus_wdone = 1'b1;
      wdone_cyc = cyc;
      @(negedge clk);
      bus_wdone = 1'b0;
    end
  endtask

  initial begin
    bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_wdone = 1'b0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0; bus_rvalid = 1'b0; bus_wdone = 1'b0;
      if (spur_req != spur_done) begin
        bus_rvalid = 1'b1;
        bus_wdone  = 1'b1;
        bus_rdata  = '1;
        spur_done++;
      end else if (bus_req && !rst) begin
        serve();
      end
    end
  end

  // ------------------------------------------------------------ completions
  task automatic handle(input logic p, input logic [511:0] data);
    sb_t e;
    valid_cnt[p]++;
    valid_cyc[p] = cyc;
    if (sb_q.size() == 0) begin
      check("completion_expected", 512'(sb_q.size()), 512'd1);
      return;
    end
    e = sb_q.pop_front();
    check("valid_port", 512'(p), 512'(e.port));
    check("data_out", data, e.data);
  endtask

  initial begin
    logic prev_req;
    prev_req = 1'b0;
    valid_cnt[0] = 0; valid_cnt[1] = 0;
    valid_cyc[0] = 0; valid_cyc[1] = 0;
    forever begin
      @(negedge clk);
      if (bus_req === 1'b1 && prev_req !== 1'b1) rises++;
      prev_req = bus_req;
      if (ic_data_valid === 1'b1) handle(P_IC, ic_data_out);
      if (dc_data_valid === 1'b1) handle(P_DC, dc_data_out);
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic expect_read(input logic p, input logic [63:0] baddr, input logic [63:0] base,
                             input int ack_dly, input int gap);
    bus_q.push_back('{baddr, 1'b0, 64'd0, base, ack_dly, gap, 0});
    model_out[p] = mk_line(base);
    sb_q.push_back('{p, model_out[p]});
  endtask

  task automatic expect_write(input logic p, input logic [63:0] baddr, input logic [63:0] data,
                              input int wdly);
    bus_q.push_back('{baddr, 1'b1, data, 64'd0, 0, 0, wdly});
    sb_q.push_back('{p, model_out[p]});
  endtask

  task automatic drive_req(input logic ic, input logic dc);
    ic_req = ic;
    dc_req = dc;
    @(negedge clk);
    ic_req = 1'b0;
    dc_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || bus_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 512'(n < budget), 512'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bus_req"},   512'(bus_req), 512'd0);
    check({tag, "_bus_addr"},  512'(bus_addr), 512'd0);
    check({tag, "_bus_wr_en"}, 512'(bus_wr_en), 512'd0);
    check({tag, "_bus_wdata"}, 512'(bus_wdata), 512'd0);
    check({tag, "_valids"},    512'({ic_data_valid, dc_data_valid}), 512'd0);
    check({tag, "_ic_out"},    ic_data_out, 512'd0);
    check({tag, "_dc_out"},    dc_data_out, 512'd0);
  endtask

  initial begin
    int req_cyc, v0, v1, n, t0;
    rst = 1'b1;
    ic_req = 1'b0; ic_addr = '0; ic_wr_en = 1'b0; ic_data_in = '0;
    dc_req = 1'b0; dc_addr = '0; dc_wr_en = 1'b0; dc_data_in = '0;
    model_out[0] = '0; model_out[1] = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: single I-cache read, zero-wait bus
    ic_addr = 64'h1234_5678; ic_wr_en = 1'b0;
    expect_read(P_IC, 64'h1234_5640, 64'h1000, 0, 0);
    req_cyc = cyc;
    drive_req(1'b1, 1'b0);
    wait_done("t1_timeout", 100);
    check("t1_latency", 512'(valid_cyc[0] - req_cyc), 512'd11);
    check("t1_beat0", 512'(ic_data_out[63:0]), 512'h1000);
    check("t1_beat7", 512'(ic_data_out[511:448]), 512'h1007);

    // 2: simultaneous requests after reset: D-cache first, then I-cache
    v0 = valid_cnt[0]; v1 = valid_cnt[1];
    ic_addr = 64'h2000; dc_addr = 64'h3048;
    expect_read(P_DC, 64'h3040, 64'h2000, 0, 0);
    expect_read(P_IC, 64'h2000, 64'h3000, 0, 0);
    drive_req(1'b1, 1'b1);
    wait_done("t2_timeout", 200);
    check("t2_ic_pulses", 512'(valid_cnt[0] - v0), 512'd1);
    check("t2_dc_pulses", 512'(valid_cnt[1] - v1), 512'd1);
    check("t2_bus_req_rises", 512'(rises), 512'd3);

    // 3: D-cache single-beat write; dc_data_out keeps the test-2 line
    dc_addr = 64'h8000_0008; dc_wr_en = 1'b1; dc_data_in = 64'hDEAD_BEEF;
    expect_write(P_DC, 64'h8000_0008, 64'hDEAD_BEEF, 2);
    drive_req(1'b0, 1'b1);
    dc_wr_en = 1'b0;
    wait_done("t3_timeout", 100);
    check("t3_valid_after_wdone", 512'(valid_cyc[1] - wdone_cyc), 512'd1);
    check("t3_dc_out_kept", dc_data_out, mk_line(64'h2000));

    // 4: late ack and gapped beats
    ic_addr = 64'h4444;
    expect_read(P_IC, 64'h4440, 64'h4000, 5, 2);
    drive_req(1'b1, 1'b0);
    wait_done("t4_timeout", 200);

    // 5: reset in the middle of a line fill, then a clean D-cache read
    dc_addr = 64'h5000;
    bus_q.push_back('{64'h5000, 1'b0, 64'd0, 64'h5000, 0, 0, 0});
    t0 = txn_cnt;
    drive_req(1'b0, 1'b1);
    n = 0;
    while (!(txn_cnt == t0 + 1 && beats_sent >= 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_beat3", 512'(n < 100), 512'd1);
    v0 = valid_cnt[0]; v1 = valid_cnt[1];
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    model_out[0] = '0; model_out[1] = '0;
    repeat (12) @(negedge clk);
    check("t5_no_pulse", 512'((valid_cnt[0] - v0) + (valid_cnt[1] - v1)), 512'd0);
    dc_addr = 64'h6010;
    expect_read(P_DC, 64'h6000, 64'h6000, 0, 0);
    drive_req(1'b0, 1'b1);
    wait_done("t5_timeout", 100);

    // 6: stray bus strobes in IDLE, then a repeated request while pending
    v1 = valid_cnt[1];
    spur_req++;
    repeat (3) @(negedge clk);
    check("t6_idle_bus_req", 512'(bus_req), 512'd0);
    check("t6_idle_no_valid", 512'(valid_cnt[1] - v1), 512'd0);
    dc_addr = 64'h7000;
    expect_read(P_DC, 64'h7000, 64'h7100, 0, 0);
    drive_req(1'b0, 1'b1);
    dc_addr = 64'h9000;
    drive_req(1'b0, 1'b1);
    wait_done("t6_timeout", 100);
    repeat (20) @(negedge clk);
    check("t6_single_completion", 512'(valid_cnt[1] - v1), 512'd1);

    check("end_sb_empty", 512'(sb_q.size()), 512'd0);
    check("end_bus_q_empty", 512'(bus_q.size()), 512'd0);
    check("end_bus_req_rises", 512'(rises), 512'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
